hls_macc_result_collector: RTL and testbench
============================================

Name: hls_macc_result_collector

Overview:
- Downstream stage of the hls_macc datapath.
- Captures the vld-qualified scalar outputs of one macc transaction (out13, out30, out31, ap_return) and assembles them into one result record per ap_done pulse.
- Buffers records in a small FIFO with a valid/ready drain interface, and keeps a running signed accumulation of ap_return.
- Provides back-pressure (start_en) so the upstream controller withholds ap_start when the buffer cannot take another record.

Parameters:
DEPTH, 4, FIFO depth in records (power of two, 2..16)
ACC_W, 48, accumulator width in bits (>=33)
CNT_W, 16, width of transaction and drop counters

Ports:
ap_clk  in  1  clock; all logic on rising edge
ap_rst  in  1  asynchronous active-high reset
m_ap_done  in  1  macc completion pulse; one cycle per transaction
m_out13  in  32  macc out13 data
m_out13_ap_vld  in  1  out13 valid strobe
m_out30  in  32  macc out30_o data
m_out30_ap_vld  in  1  out30 valid strobe (asserted only on the in1!=in2 path)
m_out31  in  32  macc out31 data
m_out31_ap_vld  in  1  out31 valid strobe
m_ap_return  in  32  macc return value; sampled only when m_ap_done=1
res_valid  out  1  FIFO head record available
res_ready  in  1  consumer accepts head record
res_out13  out  32  head record out13
res_out30  out  32  head record out30 (0 when not produced)
res_out31  out  32  head record out31
res_return  out  32  head record ap_return
res_flags  out  3  head record seen bits {out31, out30, out13}
acc_clr  in  1  synchronous clear of accumulator
acc_sum  out  ACC_W  running signed sum of ap_return
txn_count  out  CNT_W  records pushed (wraps)
drop_count  out  CNT_W  records lost to full FIFO (saturates)
overflow  out  1  sticky; set on any drop, cleared only by reset
start_en  out  1  high when FIFO has at least 2 free entries

Behaviour:
- Reset (async, ap_rst=1):
  - FSM enters IDLE; capture registers and flags are 0.
  - FIFO is emptied: res_valid=0, and all res_* outputs are 0.
  - acc_sum=0, txn_count=0, drop_count=0, overflow=0, start_en=1.
  - Reset asserted mid-transaction discards the partial capture.
- Capture:
  - Each m_*_ap_vld=1 cycle registers its data and sets its flag bit.
  - A repeated vld within one transaction overwrites the data (last value wins).
- FSM:
  - IDLE -> COLLECT on any vld without m_ap_done.
  - COLLECT -> IDLE on m_ap_done.
  - m_ap_done in IDLE also completes a record, whose flags reflect only same-cycle strobes.
- Record formation on m_ap_done:
  - out31 and ap_return are taken from the current cycle's inputs when their strobes are present; out31 flag = m_out31_ap_vld.
  - Other fields come from the capture registers, or from same-cycle strobes, which take priority.
  - A field whose flag is 0 is stored as 0.
  - Capture registers and flags clear on the next edge.
  - Exception: m_out13_ap_vld coincident with m_ap_done belongs to the NEXT transaction. It is loaded into the cleared capture, and the FSM goes to COLLECT.
- Push:
  - One push per m_ap_done; the record appears at res_* one cycle later if the FIFO was empty.
  - txn_count increments on every successful push.
- Pop:
  - Pop occurs when res_valid and res_ready are both 1; the next entry is presented on the following cycle.
  - res_* hold stable while res_valid=1 and res_ready=0.
- Full FIFO:
  - Push while full without a same-cycle pop drops the record: drop_count+1 (saturating at all-ones) and overflow<=1.
  - Push and pop in the same cycle while full succeeds, and occupancy is unchanged.
- Empty FIFO: push and pop in the same cycle is not a bypass; res_valid rises the cycle after the push.
- start_en: combinational from registered occupancy; start_en = (DEPTH - occupancy) >= 2.
- Accumulator:
  - On m_ap_done, acc_sum <= acc_sum + sign_extend(m_ap_return), modulo 2^ACC_W.
  - The accumulator updates even when the record is dropped.
  - acc_clr alone: acc_sum <= 0.
  - acc_clr with m_ap_done: acc_sum <= sign_extend(m_ap_return).
- Latency: m_ap_done to res_valid is 1 cycle when the FIFO is empty.

Test Plan:
- Long path: out13 vld with 0x5, out30 vld with 0x10, then done with out31 vld 0x20 and return 0x35 -> one record {0x5,0x10,0x20,0x35}, flags=3'b111, acc_sum=0x35, txn_count=1.
- Short path (no out30): out13 vld 0x7, then done with out31 0x9 and return 0x10 -> out30 field=0, flags=3'b101.
- Signed accumulate: returns 0xFFFFFFFF then 0x00000003 -> acc_sum=2; then acc_clr with done return 0x8 -> acc_sum=8.
- Full FIFO: res_ready=0, DEPTH+2 dones -> DEPTH records held, drop_count=2, overflow=1; start_en=0 once occupancy>=DEPTH-1.
- Push and pop while full: res_ready=1 on a done cycle -> no drop, occupancy unchanged, records drain in order.
- Reset mid-operation: ap_rst pulse after out13 vld, then done with out31 only -> record out13=0, flags=3'b100, counters restarted at 1.

Source files
------------

// File: rtl/hls_macc_result_collector_if.sv
// ---------------------------------------------------------------------------
// hls_macc_result_collector_if
//   Bundles the macc scalar-output strobes feeding the result collector and
//   the valid/ready record drain leaving it.
//   master : drives m_* strobes/data and res_ready (upstream + consumer side)
//   slave  : the collector; samples m_* and res_ready, drives res_*
// ---------------------------------------------------------------------------
interface hls_macc_result_collector_if;
  logic        m_ap_done;
  logic [31:0] m_out13;
  logic        m_out13_ap_vld;
  logic [31:0] m_out30;
  logic        m_out30_ap_vld;
  logic [31:0] m_out31;
  logic        m_out31_ap_vld;
  logic [31:0] m_ap_return;

  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_out13;
  logic [31:0] res_out30;
  logic [31:0] res_out31;
  logic [31:0] res_return;
  logic [2:0]  res_flags;

  modport master (
    output m_ap_done, m_out13, m_out13_ap_vld, m_out30, m_out30_ap_vld,
           m_out31, m_out31_ap_vld, m_ap_return, res_ready,
    input  res_valid, res_out13, res_out30, res_out31, res_return, res_flags
  );

  modport slave (
    input  m_ap_done, m_out13, m_out13_ap_vld, m_out30, m_out30_ap_vld,
           m_out31, m_out31_ap_vld, m_ap_return, res_ready,
    output res_valid, res_out13, res_out30, res_out31, res_return, res_flags
  );
endinterface

// File: rtl/hls_macc_result_collector.sv
// ---------------------------------------------------------------------------
// hls_macc_result_collector
//   Collects the vld-qualified scalar outputs of one hls_macc transaction into
//   a record on each ap_done, buffers records in a DEPTH-entry FIFO drained by
//   valid/ready, keeps a signed running sum of ap_return, and exports
//   back-pressure (start_en) for the upstream controller.
// Ports:
//   ap_clk, ap_rst   clock / asynchronous active-high reset
//   bus (slave)      m_* capture inputs, res_* record drain (valid/ready)
//   acc_clr          synchronous accumulator clear
//   acc_sum          running signed sum of ap_return (ACC_W bits, wraps)
//   txn_count        records pushed (wraps)
//   drop_count       records lost to a full FIFO (saturates)
//   overflow         sticky drop indicator
//   start_en         FIFO has at least two free entries
// ---------------------------------------------------------------------------
module hls_macc_result_collector #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ACC_W = 48,
  parameter int unsigned CNT_W = 16
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  hls_macc_result_collector_if.slave      bus,
  input  logic                            acc_clr,
  output logic [ACC_W-1:0]                acc_sum,
  output logic [CNT_W-1:0]                txn_count,
  output logic [CNT_W-1:0]                drop_count,
  output logic                            overflow,
  output logic                            start_en
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]  flags;   // {out31, out30, out13}
    logic [31:0] ret;
    logic [31:0] o31;
    logic [31:0] o30;
    logic [31:0] o13;
  } rec_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t      state_q, state_d;

  // Capture of the in-flight transaction. out31 is never captured: the
  // record only ever takes out31 from the ap_done cycle itself.
  logic [31:0] c13_q, c13_d;
  logic [31:0] c30_q, c30_d;
  logic        f13_q, f13_d;
  logic        f30_q, f30_d;

  rec_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] txn_q, drop_q;
  logic             ovf_q;

  rec_t  rec;
  rec_t  head;
  logic  any_vld;
  logic  full, empty;
  logic  push, pop, push_ok, drop;
  logic [ACC_W-1:0] ret_ext;

  assign any_vld = bus.m_out13_ap_vld | bus.m_out30_ap_vld | bus.m_out31_ap_vld;

  // ---------------------------------------------------------------------
  // FSM and capture registers
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    c13_d   = c13_q;
    c30_d   = c30_q;
    f13_d   = f13_q;
    f30_d   = f30_q;

    if (bus.m_ap_done) begin
      // Completion clears the capture; an out13 strobe on the done cycle
      // opens the next transaction rather than finishing this one.
      c13_d = '0;
      c30_d = '0;
      f13_d = 1'b0;
      f30_d = 1'b0;
      if (bus.m_out13_ap_vld) begin
        c13_d   = bus.m_out13;
        f13_d   = 1'b1;
        state_d = COLLECT;
      end else begin
        state_d = IDLE;
      end
    end else begin
      if (bus.m_out13_ap_vld) begin
        c13_d = bus.m_out13;
        f13_d = 1'b1;
      end
      if (bus.m_out30_ap_vld) begin
        c30_d = bus.m_out30;
        f30_d = 1'b1;
      end
      unique case (state_q)
        IDLE:    if (any_vld) state_d = COLLECT;
        COLLECT: state_d = COLLECT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
      c13_q   <= '0;
      c30_q   <= '0;
      f13_q   <= 1'b0;
      f30_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c13_q   <= c13_d;
      c30_q   <= c30_d;
      f13_q   <= f13_d;
      f30_q   <= f30_d;
    end
  end

  // ---------------------------------------------------------------------
  // Record formation (meaningful only when m_ap_done=1)
  // ---------------------------------------------------------------------
  always_comb begin
    rec          = '0;
    rec.flags[0] = f13_q;
    rec.flags[1] = f30_q | bus.m_out30_ap_vld;
    rec.flags[2] = bus.m_out31_ap_vld;
    rec.o13      = f13_q ? c13_q : '0;
    if (bus.m_out30_ap_vld) rec.o30 = bus.m_out30;
    else if (f30_q)         rec.o30 = c30_q;
    rec.o31      = bus.m_out31_ap_vld ? bus.m_out31 : '0;
    rec.ret      = bus.m_ap_return;
  end

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign push    = bus.m_ap_done;
  assign pop     = ~empty & bus.res_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (push_ok & ~pop)      count_d = count_q + 1'b1;
    else if (~push_ok & pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= rec;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_comb begin
    head = '0;
    if (!empty) head = mem_q[rd_ptr_q];
  end

  assign bus.res_valid  = ~empty;
  assign bus.res_out13  = head.o13;
  assign bus.res_out30  = head.o30;
  assign bus.res_out31  = head.o31;
  assign bus.res_return = head.ret;
  assign bus.res_flags  = head.flags;

  assign start_en = (count_q <= (PTR_W+1)'(DEPTH - 2));

  // ---------------------------------------------------------------------
  // Accumulator and counters
  // ---------------------------------------------------------------------
  assign ret_ext = {{(ACC_W-32){bus.m_ap_return[31]}}, bus.m_ap_return};

  always_comb begin
    acc_d = acc_q;
    if (acc_clr)             acc_d = bus.m_ap_done ? ret_ext : '0;
    else if (bus.m_ap_done)  acc_d = acc_q + ret_ext;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q  <= '0;
      txn_q  <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (push_ok) txn_q <= txn_q + 1'b1;
      if (drop) begin
        ovf_q <= 1'b1;
        if (~&drop_q) drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign acc_sum    = acc_q;
  assign txn_count  = txn_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_hls_macc_result_collector.sv
module tb_hls_macc_result_collector;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned ACC_W = 48;
  localparam int unsigned CNT_W = 16;

  logic             ap_clk = 1'b0;
  logic             ap_rst = 1'b1;
  logic             acc_clr = 1'b0;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] txn_count, drop_count;
  logic             overflow, start_en;

  hls_macc_result_collector_if bus ();

  hls_macc_result_collector #(.DEPTH(DEPTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .bus        (bus),
    .acc_clr    (acc_clr),
    .acc_sum    (acc_sum),
    .txn_count  (txn_count),
    .drop_count (drop_count),
    .overflow   (overflow),
    .start_en   (start_en)
  );

  always #5 ap_clk = ~ap_clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] o13, o30, o31, ret;
    logic [2:0]  fl;
  } rec_t;

  rec_t             mq[$];
  logic [ACC_W-1:0] m_acc;
  int unsigned      m_txn, m_drop;
  bit               m_ovf;
  bit               p13v, p30v;
  logic [31:0]      p13, p30;

  always @(negedge ap_clk) begin : model
    automatic rec_t r;
    automatic bit   pop;
    automatic int   sz;
    if (ap_rst) begin
      mq.delete();
      m_acc = '0; m_txn = 0; m_drop = 0; m_ovf = 0;
      p13v = 0; p30v = 0; p13 = '0; p30 = '0;
    end

    // compare DUT against the model state reached so far
    chk("res_valid", 64'(bus.res_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) r = mq[0]; else r = '0;
    chk("res_out13",  64'(bus.res_out13),  64'(r.o13));
    chk("res_out30",  64'(bus.res_out30),  64'(r.o30));
    chk("res_out31",  64'(bus.res_out31),  64'(r.o31));
    chk("res_return", 64'(bus.res_return), 64'(r.ret));
    chk("res_flags",  64'(bus.res_flags),  64'(r.fl));
    chk("acc_sum",    64'(acc_sum),        64'(m_acc));
    chk("txn_count",  64'(txn_count),      64'(m_txn % (1 << CNT_W)));
    chk("drop_count", 64'(drop_count),     64'(m_drop));
    chk("overflow",   64'(overflow),       64'(m_ovf));
    chk("start_en",   64'(start_en),       64'((DEPTH - mq.size()) >= 2));

    // advance the model with the inputs the next rising edge will see
    if (!ap_rst) begin
      sz  = mq.size();
      pop = (sz != 0) && bus.res_ready;
      if (acc_clr)
        m_acc = bus.m_ap_done ? ACC_W'($signed(bus.m_ap_return)) : '0;
      else if (bus.m_ap_done)
        m_acc = m_acc + ACC_W'($signed(bus.m_ap_return));
      if (pop) void'(mq.pop_front());
      if (bus.m_ap_done) begin
        r.o13 = p13v ? p13 : 32'h0;
        r.o30 = bus.m_out30_ap_vld ? bus.m_out30 : (p30v ? p30 : 32'h0);
        r.o31 = bus.m_out31_ap_vld ? bus.m_out31 : 32'h0;
        r.ret = bus.m_ap_return;
        r.fl  = {bus.m_out31_ap_vld, bus.m_out30_ap_vld | p30v, p13v};
        if (sz == DEPTH && !pop) begin
          m_ovf = 1;
          if (m_drop < (1 << CNT_W) - 1) m_drop++;
        end else begin
          mq.push_back(r);
          m_txn++;
        end
        p13v = bus.m_out13_ap_vld; p13 = bus.m_out13_ap_vld ? bus.m_out13 : 32'h0;
        p30v = 0; p30 = '0;
      end else begin
        if (bus.m_out13_ap_vld) begin p13v = 1; p13 = bus.m_out13; end
        if (bus.m_out30_ap_vld) begin p30v = 1; p30 = bus.m_out30; end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge ap_clk); #1;
  endtask

  task automatic drive(input bit done, input bit v13, input logic [31:0] d13,
                       input bit v30, input logic [31:0] d30,
                       input bit v31, input logic [31:0] d31,
                       input logic [31:0] ret, input bit clr);
    bus.m_ap_done = done;
    bus.m_out13_ap_vld = v13; bus.m_out13 = d13;
    bus.m_out30_ap_vld = v30; bus.m_out30 = d30;
    bus.m_out31_ap_vld = v31; bus.m_out31 = d31;
    bus.m_ap_return = ret;
    acc_clr = clr;
    tick();
    bus.m_ap_done = 0; bus.m_out13_ap_vld = 0; bus.m_out30_ap_vld = 0;
    bus.m_out31_ap_vld = 0; acc_clr = 0;
    bus.m_out13 = '0; bus.m_out30 = '0; bus.m_out31 = '0; bus.m_ap_return = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.m_ap_done = 0; bus.m_out13_ap_vld = 0; bus.m_out30_ap_vld = 0;
    bus.m_out31_ap_vld = 0; bus.m_out13 = '0; bus.m_out30 = '0;
    bus.m_out31 = '0; bus.m_ap_return = '0; bus.res_ready = 1;
    tick(); tick();
    chk("rst_start_en", 64'(start_en), 64'd1);
    chk("rst_valid",    64'(bus.res_valid), 64'd0);
    ap_rst = 0;
    idle(1);

    // long path
    drive(0, 1, 32'h5, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h10, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 32'h20, 32'h35, 0);
    chk("long_valid", 64'(bus.res_valid), 64'd1);
    chk("long_o13",   64'(bus.res_out13), 64'h5);
    chk("long_o30",   64'(bus.res_out30), 64'h10);
    chk("long_o31",   64'(bus.res_out31), 64'h20);
    chk("long_ret",   64'(bus.res_return), 64'h35);
    chk("long_flags", 64'(bus.res_flags), 64'b111);
    chk("long_acc",   64'(acc_sum), 64'h35);
    chk("long_txn",   64'(txn_count), 64'd1);

    // short path
    drive(0, 1, 32'h7, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 32'h9, 32'h10, 0);
    chk("short_o13",   64'(bus.res_out13), 64'h7);
    chk("short_o30",   64'(bus.res_out30), 64'h0);
    chk("short_flags", 64'(bus.res_flags), 64'b101);

    // signed accumulate
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_acc", 64'(acc_sum), 64'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
    chk("neg_acc", 64'(acc_sum), 64'hFFFF_FFFF_FFFF);
    drive(1, 0, 0, 0, 0, 0, 0, 32'h3, 0);
    chk("sum_acc", 64'(acc_sum), 64'd2);
    drive(1, 0, 0, 0, 0, 0, 0, 32'h8, 1);
    chk("clrdone_acc", 64'(acc_sum), 64'd8);

    // repeated out30 strobe: last value wins
    drive(0, 0, 0, 1, 32'h1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h2, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 32'h4, 0);
    chk("rep_o30",   64'(bus.res_out30), 64'h2);
    chk("rep_flags", 64'(bus.res_flags), 64'b010);

    // out13 with done starts the next transaction
    drive(1, 1, 32'hAA, 0, 0, 0, 0, 32'h0, 0);
    chk("exc1_flags", 64'(bus.res_flags), 64'b000);
    drive(1, 0, 0, 0, 0, 1, 32'h1, 32'h0, 0);
    chk("exc2_o13",   64'(bus.res_out13), 64'hAA);
    chk("exc2_flags", 64'(bus.res_flags), 64'b101);
    idle(2);

    // full FIFO with back-pressure
    bus.res_ready = 0;
    for (int i = 0; i < DEPTH + 2; i++)
      drive(1, 0, 0, 0, 0, 1, 32'h100 + i, 32'(i), 0);
    chk("full_valid", 64'(bus.res_valid), 64'd1);
    chk("full_head",  64'(bus.res_out31), 64'h100);
    chk("full_drop",  64'(drop_count), 64'd2);
    chk("full_ovf",   64'(overflow), 64'd1);
    chk("full_sten",  64'(start_en), 64'd0);
    chk("full_txn",   64'(txn_count), 64'd12);

    // push and pop together while full
    bus.res_ready = 1;
    drive(1, 0, 0, 0, 0, 1, 32'h200, 32'h9, 0);
    chk("pp_drop", 64'(drop_count), 64'd2);
    chk("pp_head", 64'(bus.res_out31), 64'h101);
    idle(DEPTH + 2);
    chk("drain_sten", 64'(start_en), 64'd1);

    // reset mid-transaction
    drive(0, 1, 32'h11, 0, 0, 0, 0, 0, 0);
    ap_rst = 1;
    tick();
    chk("rst_ovf", 64'(overflow), 64'd0);
    ap_rst = 0;
    drive(1, 0, 0, 0, 0, 1, 32'h22, 32'h1, 0);
    chk("rst_o13",   64'(bus.res_out13), 64'h0);
    chk("rst_flags", 64'(bus.res_flags), 64'b100);
    chk("rst_txn",   64'(txn_count), 64'd1);
    chk("rst_acc",   64'(acc_sum), 64'd1);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
